// File: rtl/audio_sram_ctrl.sv
// Records ADC samples into consecutive SRAM words and plays them back to the DAC on request.
// Write lasts WR_CYCLES after adc_valid, a sample lands RD_CYCLES+1 after dac_req; no backpressure, samples arriving mid-write are dropped.
module audio_sram_ctrl #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              record,
    input  logic              play,
    input  logic              stop,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              dac_req,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic [ADDR_W-1:0] addr,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   rec_len,
    output logic              busy,
    output logic              mem_full,
    output logic              overrun,
    output logic              play_done
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REC_WAIT  = 3'd1;
    localparam logic [2:0] S_REC_WR    = 3'd2;
    localparam logic [2:0] S_PLAY_WAIT = 3'd3;
    localparam logic [2:0] S_PLAY_RD   = 3'd4;

    localparam int CNT_MAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stop_pend_q, stop_pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] dac_data_q, dac_data_d;
    logic [ADDR_W:0]   rec_len_q, rec_len_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              dac_valid_q, dac_valid_d;
    logic              busy_q, busy_d;
    logic              mem_full_q, mem_full_d;
    logic              overrun_q, overrun_d;
    logic              play_done_q, play_done_d;

    logic [ADDR_W:0]   addr_nxt;
    logic              stopping;
    logic              last_sample;

    assign addr_nxt    = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};
    assign stopping    = stop_pend_q | stop;
    assign last_sample = (addr_nxt == rec_len_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        dac_data_d  = dac_data_q;
        rec_len_d   = rec_len_q;
        read_d      = read_q;
        write_d     = write_q;
        mem_full_d  = mem_full_q;
        overrun_d   = overrun_q;
        dac_valid_d = 1'b0;
        play_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (record) begin
                    state_d    = S_REC_WAIT;
                    addr_d     = '0;
                    rec_len_d  = '0;
                    mem_full_d = 1'b0;
                    overrun_d  = 1'b0;
                end else if (play && (rec_len_q != '0)) begin
                    state_d = S_PLAY_WAIT;
                    addr_d  = '0;
                end
            end

            S_REC_WAIT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (adc_valid) begin
                    wr_data_d = adc_data;
                    write_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_REC_WR;
                end
            end

            S_REC_WR: begin
                if (adc_valid) begin
                    overrun_d = 1'b1;
                end
                stop_pend_d = stopping;
                if (cnt_q == WR_LAST) begin
                    write_d     = 1'b0;
                    rec_len_d   = addr_nxt;
                    stop_pend_d = 1'b0;
                    // The top word is the last one: recording ends there instead of wrapping.
                    if (addr_q == ADDR_TOP) begin
                        mem_full_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        addr_d  = addr_nxt[ADDR_W-1:0];
                        state_d = stopping ? S_IDLE : S_REC_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_PLAY_WAIT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (dac_req) begin
                    read_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_PLAY_RD;
                end
            end

            S_PLAY_RD: begin
                stop_pend_d = stopping;
                if (cnt_q == RD_LAST) begin
                    read_d      = 1'b0;
                    dac_data_d  = rd_data;
                    dac_valid_d = 1'b1;
                    stop_pend_d = 1'b0;
                    // A latched stop still delivers this sample but suppresses play_done.
                    play_done_d = last_sample & ~stopping;
                    addr_d      = last_sample ? '0 : addr_nxt[ADDR_W-1:0];
                    state_d     = (last_sample | stopping) ? S_IDLE : S_PLAY_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            dac_data_q  <= '0;
            rec_len_q   <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            dac_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mem_full_q  <= 1'b0;
            overrun_q   <= 1'b0;
            play_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            dac_data_q  <= dac_data_d;
            rec_len_q   <= rec_len_d;
            read_q      <= read_d;
            write_q     <= write_d;
            dac_valid_q <= dac_valid_d;
            busy_q      <= busy_d;
            mem_full_q  <= mem_full_d;
            overrun_q   <= overrun_d;
            play_done_q <= play_done_d;
        end
    end

    assign dac_data  = dac_data_q;
    assign dac_valid = dac_valid_q;
    assign addr      = addr_q;
    assign read      = read_q;
    assign write     = write_q;
    assign wr_data   = wr_data_q;
    assign rec_len   = rec_len_q;
    assign busy      = busy_q;
    assign mem_full  = mem_full_q;
    assign overrun   = overrun_q;
    assign play_done = play_done_q;

endmodule

// File: tb/tb_audio_sram_ctrl.sv
// Bench for audio_sram_ctrl: random recordings are kept as sample lists and replayed through an SRAM model.
module tb_audio_sram_ctrl;

    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int WRC = 2;
    localparam int RDC = 2;

    logic          clk = 1'b0;
    logic          reset, record, play, stop, adc_valid, dac_req;
    logic [DW-1:0] adc_data, rd_data, dac_data, wr_data;
    logic          dac_valid, read, write, busy, mem_full, overrun, play_done;
    logic [AW-1:0] addr;
    logic [AW:0]   rec_len;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] wlog_a[$];
    logic [DW-1:0] wlog_d[$];
    logic [AW-1:0] rlog[$];

    always #5 clk = ~clk;

    audio_sram_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(WRC), .RD_CYCLES(RDC)
    ) dut (
        .clk(clk), .reset(reset), .record(record), .play(play), .stop(stop),
        .adc_data(adc_data), .adc_valid(adc_valid), .dac_req(dac_req),
        .dac_data(dac_data), .dac_valid(dac_valid), .addr(addr), .read(read),
        .write(write), .wr_data(wr_data), .rd_data(rd_data), .rec_len(rec_len),
        .busy(busy), .mem_full(mem_full), .overrun(overrun), .play_done(play_done)
    );

    always @(posedge clk) if (write) sram[addr] <= wr_data;
    assign rd_data = read ? sram[addr] : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus monitor: logs every write/read request and checks pulse shape and stability.
    logic          wr_prev = 1'b0, rd_prev = 1'b0;
    int            wr_len = 0;
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;
    always @(negedge clk) begin
        if (reset) begin
            wr_prev = 1'b0;
            rd_prev = 1'b0;
            wr_len  = 0;
        end else begin
            if (read || write) chk("rw_excl", 32'(read & write), 32'd0);
            if (write && !wr_prev) begin
                wlog_a.push_back(addr);
                wlog_d.push_back(wr_data);
                hold_a = addr;
                hold_d = wr_data;
                wr_len = 1;
            end else if (write) begin
                wr_len++;
                chk("wr_hold_addr", 32'(addr), 32'(hold_a));
                chk("wr_hold_data", 32'(wr_data), 32'(hold_d));
            end else if (wr_prev) begin
                chk("wr_len", wr_len, WRC);
            end
            if (read && !rd_prev) begin
                rlog.push_back(addr);
                hold_a = addr;
            end else if (read) begin
                chk("rd_hold_addr", 32'(addr), 32'(hold_a));
            end
            wr_prev = write;
            rd_prev = read;
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_addr"}, 32'(addr), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
        chk({tag, "_dac_data"}, 32'(dac_data), 0);
        chk({tag, "_rec_len"}, 32'(rec_len), 0);
        chk({tag, "_ctl"}, 32'({read, write, dac_valid, busy, mem_full, overrun, play_done}), 0);
    endtask

    task automatic adc_pulse(input logic [DW-1:0] d);
        adc_data  = d;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    // Records src_q; gap 0 means random spacing, dbl injects a back-to-back sample at index 1.
    task automatic record_run(input int gap, input int dbl, input int stop_wr);
        int   n;
        logic ovr;
        n   = src_q.size();
        ovr = 1'b0;
        wlog_a.delete();
        wlog_d.delete();
        exp_q.delete();
        record = 1'b1; tick(); record = 1'b0;
        chk("rec_start_busy", 32'(busy), 1);
        chk("rec_start_len", 32'(rec_len), 0);
        chk("rec_start_flags", 32'({mem_full, overrun}), 0);
        for (int i = 0; i < n; i++) begin
            adc_data  = src_q[i];
            adc_valid = 1'b1;
            tick();
            exp_q.push_back(src_q[i]);
            if (dbl != 0 && i == 1) begin
                adc_data = ~src_q[i];
                tick();
                ovr = 1'b1;
            end
            adc_valid = 1'b0;
            if (stop_wr != 0 && i == n - 1) begin
                stop = 1'b1; tick(); stop = 1'b0;
            end
            repeat ((gap > 0) ? gap : $urandom_range(2, 5)) tick();
        end
        if (stop_wr == 0) begin
            stop = 1'b1; tick(); stop = 1'b0;
        end
        tick();
        chk("rec_end_busy", 32'(busy), 0);
        chk("rec_len", 32'(rec_len), n);
        chk("overrun", 32'(overrun), 32'(ovr));
        chk("rec_mem_full", 32'(mem_full), 0);
        chk("wr_count", wlog_a.size(), n);
        for (int i = 0; i < n && i < wlog_a.size(); i++) begin
            chk("wr_addr", 32'(wlog_a[i]), i);
            chk("wr_data", 32'(wlog_d[i]), 32'(exp_q[i]));
        end
    endtask

    // Plays back n samples and compares against exp_q; sometimes holds dac_req into the read.
    task automatic play_all(input int n);
        int lat;
        rlog.delete();
        play = 1'b1; tick(); play = 1'b0;
        chk("play_busy", 32'(busy), 1);
        chk("play_addr0", 32'(addr), 0);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            dac_req = 1'b1;
            tick();
            lat = 1;
            if ($urandom_range(0, 1) == 1) begin
                tick();
                lat = 2;
            end
            dac_req = 1'b0;
            while (!dac_valid && lat < 20) begin
                tick();
                lat++;
            end
            chk("dac_lat", lat, RDC + 1);
            chk("dac_data", 32'(dac_data), 32'(exp_q[i]));
            chk("play_done", 32'(play_done), 32'(i == n - 1));
        end
        tick();
        chk("play_end_busy", 32'(busy), 0);
        chk("play_end_addr", 32'(addr), 0);
        chk("dac_valid_pulse", 32'(dac_valid), 0);
        chk("rd_count", rlog.size(), n);
        for (int i = 0; i < n && i < rlog.size(); i++) chk("rd_addr", 32'(rlog[i]), i);
    endtask

    initial begin
        int lat;
        int n;
        reset = 1'b1; record = 1'b0; play = 1'b0; stop = 1'b0;
        adc_valid = 1'b0; dac_req = 1'b0; adc_data = '0;
        tick(); tick();
        chk_reset_state("reset");
        reset = 1'b0;
        tick();

        // play with nothing recorded
        rlog.delete();
        play = 1'b1; tick(); play = 1'b0;
        repeat (3) tick();
        chk("empty_play_busy", 32'(busy), 0);
        chk("empty_play_reads", rlog.size(), 0);

        src_q = '{16'h1111, 16'h2222, 16'h3333};
        record_run(7, 0, 0);
        play_all(3);

        // stop latched during a read: sample still delivered, no play_done
        play = 1'b1; tick(); play = 1'b0;
        dac_req = 1'b1; tick(); dac_req = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        lat = 2;
        while (!dac_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("stop_rd_lat", lat, RDC + 1);
        chk("stop_rd_data", 32'(dac_data), 32'h1111);
        chk("stop_rd_done", 32'(play_done), 0);
        tick();
        chk("stop_rd_busy", 32'(busy), 0);

        // stop while waiting for dac_req
        play = 1'b1; tick(); play = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_wait_busy", 32'(busy), 0);
        chk("len_survives", 32'(rec_len), 3);
        play_all(3);

        src_q = '{16'hA5A5, 16'h5A5A, 16'h0F0F};
        record_run(0, 1, 0);
        play_all(3);

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(3, 8);
            src_q.delete();
            for (int i = 0; i < n; i++) src_q.push_back(DW'($urandom));
            record_run(0, $urandom_range(0, 1), $urandom_range(0, 1));
            play_all(n);
        end

        // fill memory: 17 samples offered, only 16 words exist
        wlog_a.delete();
        wlog_d.delete();
        exp_q.delete();
        record = 1'b1; tick(); record = 1'b0;
        for (int i = 0; i < 17; i++) begin
            src_q[0] = DW'($urandom);
            if (i < 16) exp_q.push_back(src_q[0]);
            adc_pulse(src_q[0]);
            repeat (3) tick();
        end
        chk("full_mem_full", 32'(mem_full), 1);
        chk("full_rec_len", 32'(rec_len), 16);
        chk("full_addr", 32'(addr), 15);
        chk("full_busy", 32'(busy), 0);
        chk("full_overrun", 32'(overrun), 0);
        chk("full_wr_count", wlog_a.size(), 16);
        for (int i = 0; i < 16 && i < wlog_a.size(); i++) begin
            chk("full_wr_addr", 32'(wlog_a[i]), i);
            chk("full_wr_data", 32'(wlog_d[i]), 32'(exp_q[i]));
        end
        play_all(16);

        // record and play together: record wins
        wlog_a.delete();
        wlog_d.delete();
        rlog.delete();
        record = 1'b1; play = 1'b1; tick(); record = 1'b0; play = 1'b0;
        chk("both_busy", 32'(busy), 1);
        chk("both_rec_len", 32'(rec_len), 0);
        adc_pulse(16'hBEEF);
        repeat (4) tick();
        chk("both_wr_count", wlog_a.size(), 1);
        chk("both_rd_count", rlog.size(), 0);
        if (wlog_a.size() > 0) chk("both_wr_data", 32'(wlog_d[0]), 32'hBEEF);
        stop = 1'b1; tick(); stop = 1'b0;
        tick();
        chk("both_end_busy", 32'(busy), 0);
        chk("both_end_len", 32'(rec_len), 1);

        // reset during the second write cycle
        record = 1'b1; tick(); record = 1'b0;
        adc_pulse(16'h7777);
        chk("pre_rst_write", 32'(write), 1);
        tick();
        chk("pre_rst_write2", 32'(write), 1);
        reset = 1'b1;
        tick();
        chk_reset_state("midwr_reset");
        reset = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
